// File: rtl/cdc_handshake_responder_pkg.sv
// Shared constants and state encoding for the toggle-handshake CDC endpoints.
package cdc_handshake_responder_pkg;
  localparam int DEFAULT_DATA_WIDTH  = 32;
  localparam int DEFAULT_SYNC_STAGES = 3;

  // HOLD doubles as the out_valid bit.
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;
endpackage

// File: rtl/cdc_handshake_responder_sync_chain.sv
// Multi-flop level synchronizer for a single asynchronous bit.
module SyncChain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic x,
  output logic x_sync
);
  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[STAGES-2:0], x};
  end

  assign x_sync = sync_q[STAGES-1];
endmodule

// File: rtl/cdc_handshake_responder.sv
// Destination side of a toggle req/ack CDC handshake: syncs req_toggle,
// captures the bundled word, offers it on valid/ready, returns ack_toggle.
module cdc_handshake_responder
  import cdc_handshake_responder_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_toggle,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  ack_toggle,
  output logic                  overrun
);
  state_t state, state_nxt;
  logic   req_sync, prev_req_sync, req_event;
  logic   capture, accept;

  SyncChain #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .x      (req_toggle),
    .x_sync (req_sync)
  );

  assign req_event = req_sync ^ prev_req_sync;

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: if (req_event) begin
        capture   = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: if (out_ready) begin
        accept    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // req_data is sampled raw: it has been stable for the whole sync latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      prev_req_sync <= 1'b0;
      out_data      <= '0;
      ack_toggle    <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      state         <= state_nxt;
      prev_req_sync <= req_sync;
      if (capture) out_data   <= req_data;
      if (accept)  ack_toggle <= ~ack_toggle;
      // Events arriving while a word is held are dropped, but flagged.
      if (state == HOLD && req_event) overrun <= 1'b1;
    end
  end

  assign out_valid = (state == HOLD);
endmodule

// File: tb/tb_cdc_handshake_responder.sv
// Directed bench for cdc_handshake_responder.
module tb_cdc_handshake_responder;
  localparam int DW = 32;
  localparam int SS = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_toggle = 1'b0;
  logic [DW-1:0] req_data = '0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic          ack_toggle;
  logic          overrun;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  cdc_handshake_responder #(.DATA_WIDTH(DW), .SYNC_STAGES(SS)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_toggle(req_toggle),
    .req_data  (req_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .ack_toggle(ack_toggle),
    .overrun   (overrun)
  );

  // Publish a word and flip the request 2 time units after a rising edge.
  task automatic flip(input logic [DW-1:0] d);
    @(posedge clk); #2;
    req_data   = d;
    req_toggle = ~req_toggle;
  endtask

  // Count rising edges until out_valid is seen high; -1 on timeout.
  task automatic wait_valid(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin n = i; break; end
    end
  endtask

  task automatic test_reset;
    #1;
    vectors++;
    if ({out_valid, out_data, ack_toggle, overrun} !== {1'b0, 32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: got v=%b d=%h a=%b o=%b want 0/0/0/0",
               out_valid, out_data, ack_toggle, overrun);
    end
    @(posedge clk); #2; reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_single;
    int n;
    out_ready = 1'b1;
    flip(32'h12345678);
    wait_valid(n);
    vectors++;
    if (n !== 4) begin errors++; $display("FAIL single_latency: edges=%0d want 4", n); end
    vectors++;
    if (out_data !== 32'h12345678) begin
      errors++; $display("FAIL single_data: got %h want 12345678", out_data);
    end
    vectors++;
    if (ack_toggle !== 1'b0) begin errors++; $display("FAIL single_ack_early: got %b want 0", ack_toggle); end
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL single_one_cycle: out_valid=%b want 0", out_valid); end
    vectors++;
    if (ack_toggle !== 1'b1) begin errors++; $display("FAIL single_ack: got %b want 1", ack_toggle); end
    vectors++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL single_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_backpressure;
    int n;
    out_ready = 1'b0;
    repeat (4) @(posedge clk);
    flip(32'h12345678);
    wait_valid(n);
    vectors++;
    if (n !== 4) begin errors++; $display("FAIL bp_latency: edges=%0d want 4", n); end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 32'h12345678 || ack_toggle !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold[%0d]: v=%b d=%h a=%b want 1/12345678/1",
                 i, out_valid, out_data, ack_toggle);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0 || ack_toggle !== 1'b0) begin
      errors++; $display("FAIL bp_accept: v=%b a=%b want 0/0", out_valid, ack_toggle);
    end
    @(posedge clk); #1;
    vectors++;
    if (ack_toggle !== 1'b0) begin errors++; $display("FAIL bp_single_flip: a=%b want 0", ack_toggle); end
  endtask

  task automatic test_sequence;
    logic exp_ack;
    exp_ack = 1'b0;
    out_ready = 1'b0;
    for (int w = 0; w < 8; w++) begin
      bit got;
      logic [DW-1:0] rx;
      got = 1'b0;
      rx  = '0;
      flip(DW'(w));
      for (int c = 0; c < 60 && !got; c++) begin
        bit take;
        @(negedge clk);
        out_ready = (c > 20) ? 1'b1 : 1'(($urandom_range(0, 2)) == 0);
        take = out_valid && out_ready;
        rx   = out_data;
        @(posedge clk); #1;
        if (take) got = 1'b1;
      end
      out_ready = 1'b0;
      exp_ack   = ~exp_ack;
      vectors++;
      if (!got || rx !== DW'(w)) begin
        errors++; $display("FAIL seq_word[%0d]: got=%b data=%h want %h", w, got, rx, DW'(w));
      end
      vectors++;
      if (ack_toggle !== exp_ack) begin
        errors++; $display("FAIL seq_ack[%0d]: a=%b want %b", w, ack_toggle, exp_ack);
      end
      repeat (3) @(posedge clk);
    end
    #1;
    vectors++;
    if (ack_toggle !== 1'b0 || overrun !== 1'b0) begin
      errors++; $display("FAIL seq_end: a=%b o=%b want 0/0", ack_toggle, overrun);
    end
  endtask

  task automatic test_overrun;
    int n;
    out_ready = 1'b0;
    flip(32'h000000A5);
    wait_valid(n);
    vectors++;
    if (n !== 4 || out_data !== 32'hA5) begin
      errors++; $display("FAIL ovr_first: edges=%0d d=%h want 4/a5", n, out_data);
    end
    flip(32'h0000005A);
    repeat (6) @(posedge clk);
    #1;
    vectors++;
    if (overrun !== 1'b1 || out_data !== 32'hA5 || out_valid !== 1'b1) begin
      errors++; $display("FAIL ovr_flag: o=%b d=%h v=%b want 1/a5/1", overrun, out_data, out_valid);
    end
    flip(32'h0000005A);
    repeat (6) @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0 || ack_toggle !== 1'b1) begin
      errors++; $display("FAIL ovr_accept: v=%b a=%b want 0/1", out_valid, ack_toggle);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b0 || overrun !== 1'b1 || ack_toggle !== 1'b1) begin
        errors++;
        $display("FAIL ovr_drop[%0d]: v=%b o=%b a=%b want 0/1/1", i, out_valid, overrun, ack_toggle);
      end
    end
  endtask

  task automatic test_reset_mid_hold;
    int n;
    out_ready = 1'b0;
    flip(32'hDEADBEEF);
    wait_valid(n);
    vectors++;
    if (out_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rst_hold_setup: d=%h want deadbeef", out_data);
    end
    @(posedge clk); #3;
    reset_n    = 1'b0;
    req_toggle = 1'b0;
    #1;
    vectors++;
    if ({out_valid, out_data, ack_toggle, overrun} !== {1'b0, 32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rst_async: v=%b d=%h a=%b o=%b want 0/0/0/0",
               out_valid, out_data, ack_toggle, overrun);
    end
  endtask

  task automatic test_reset_release_high;
    int n;
    req_toggle = 1'b1;
    req_data   = 32'hC0FFEE11;
    out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #2; reset_n = 1'b1;
    wait_valid(n);
    vectors++;
    if (n !== SS + 1 || out_data !== 32'hC0FFEE11) begin
      errors++; $display("FAIL rel_high: edges=%0d d=%h want %0d/c0ffee11", n, out_data, SS + 1);
    end
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0 || ack_toggle !== 1'b1 || overrun !== 1'b0) begin
      errors++; $display("FAIL rel_ack: v=%b a=%b o=%b want 0/1/0", out_valid, ack_toggle, overrun);
    end
    repeat (8) @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0 || ack_toggle !== 1'b1) begin
      errors++; $display("FAIL rel_once: v=%b a=%b want 0/1", out_valid, ack_toggle);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_backpressure;
    test_sequence;
    test_overrun;
    test_reset_mid_hold;
    test_reset_release_high;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
